// File: rtl/xif_mem_pkg.sv
// Shared types and helpers for the CV-X-IF memory responder.
package xif_mem_pkg;

    localparam int unsigned XifIdWidth = 4;

    typedef enum logic [1:0] {
        MemByte = 2'd0,
        MemHalf = 2'd1,
        MemWord = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic [XifIdWidth-1:0] id;
        logic                  we;
        logic [1:0]            offset;
        mem_size_e             size;
    } mem_meta_t;

    function automatic logic [3:0] mem_be(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] base;
        case (size)
            MemByte: base = 4'b0001;
            MemHalf: base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << offset;
    endfunction

    // Size 3 is illegal and reported as misaligned.
    function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            MemByte: mis = 1'b0;
            MemHalf: mis = offset[0];
            MemWord: mis = (offset != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/xif_mem_meta_fifo.sv
// In-order FIFO of per-transaction metadata for granted OBI accesses.
module xif_mem_meta_fifo
    import xif_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push_i,
    input  mem_meta_t push_data_i,
    input  logic      pop_i,
    output mem_meta_t head_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    mem_meta_t       r_mem [DEPTH];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_cnt;
    logic            w_push;
    logic            w_pop;

    assign full_o  = (r_cnt == FullCnt);
    assign empty_o = (r_cnt == '0);
    assign head_o  = r_mem[r_rd_ptr];
    assign w_pop   = pop_i & ~empty_o;
    // A pop frees the slot being written when full.
    assign w_push  = push_i & (~full_o | w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

endmodule

// File: rtl/xif_mem_responder.sv
// CV-X-IF memory request/result responder driving the core's OBI data port.
// One request register, in-order outstanding tracking, one result per accepted request.
module xif_mem_responder
    import xif_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ID_WIDTH        = XifIdWidth,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  x_mem_valid_i,
    output logic                  x_mem_ready_o,
    input  logic [ID_WIDTH-1:0]   x_mem_id_i,
    input  logic [ADDR_WIDTH-1:0] x_mem_addr_i,
    input  logic                  x_mem_we_i,
    input  logic [1:0]            x_mem_size_i,
    input  logic [DATA_WIDTH-1:0] x_mem_wdata_i,
    input  logic                  x_mem_last_i,
    output logic                  x_mem_result_valid_o,
    output logic [ID_WIDTH-1:0]   x_mem_result_id_o,
    output logic [DATA_WIDTH-1:0] x_mem_result_rdata_o,
    output logic                  x_mem_result_err_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,
    input  logic                  data_err_i
);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUTSTANDING);

    logic                  r_active;
    logic                  r_req_full;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [1:0]            r_size;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [CntW-1:0]       r_count;
    logic                  r_res_valid;
    logic [ID_WIDTH-1:0]   r_res_id;
    logic [DATA_WIDTH-1:0] r_res_rdata;
    logic                  r_res_err;

    logic                  w_in_mis;
    logic                  w_req_mis;
    logic                  w_accept;
    logic                  w_gnt;
    logic                  w_rsp;
    logic                  w_mis_done;
    mem_meta_t             w_push_meta;
    mem_meta_t             w_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_unused;

    assign w_unused = ^{x_mem_last_i, w_fifo_full, w_fifo_empty};

    assign w_in_mis   = mem_misaligned(x_mem_size_i, x_mem_addr_i[1:0]);
    assign w_req_mis  = mem_misaligned(r_size, r_addr[1:0]);
    // Misaligned requests bypass the bus, so they wait for an idle pipeline to keep order.
    assign x_mem_ready_o = r_active & ~r_req_full & (r_count < MaxCnt) &
                           (~w_in_mis | ((r_count == '0) & ~r_res_valid));
    assign w_accept   = x_mem_valid_i & x_mem_ready_o;
    assign data_req_o = r_req_full & ~w_req_mis;
    assign w_gnt      = data_req_o & data_gnt_i;
    assign w_mis_done = r_req_full & w_req_mis;
    assign w_rsp      = data_rvalid_i & (r_count != '0);

    assign data_addr_o  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign data_we_o    = r_we;
    assign data_be_o    = r_req_full ? mem_be(r_size, r_addr[1:0]) : 4'b0000;
    assign data_wdata_o = r_wdata << {r_addr[1:0], 3'b000};

    assign w_push_meta.id     = XifIdWidth'(r_id);
    assign w_push_meta.we     = r_we;
    assign w_push_meta.offset = r_addr[1:0];
    assign w_push_meta.size   = mem_size_e'(r_size);

    xif_mem_meta_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_meta_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (w_gnt),
        .push_data_i(w_push_meta),
        .pop_i      (w_rsp),
        .head_o     (w_head),
        .full_o     (w_fifo_full),
        .empty_o    (w_fifo_empty)
    );

    always_comb begin
        w_shifted   = data_rdata_i >> {w_head.offset, 3'b000};
        w_load_data = w_shifted;
        case (w_head.size)
            MemByte: w_load_data = DATA_WIDTH'(w_shifted[7:0]);
            MemHalf: w_load_data = DATA_WIDTH'(w_shifted[15:0]);
            default: w_load_data = w_shifted;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_active   <= 1'b0;
            r_req_full <= 1'b0;
            r_id       <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_wdata    <= '0;
        end else begin
            r_active <= 1'b1;
            if (w_accept) begin
                r_req_full <= 1'b1;
                r_id       <= x_mem_id_i;
                r_addr     <= x_mem_addr_i;
                r_we       <= x_mem_we_i;
                r_size     <= x_mem_size_i;
                r_wdata    <= x_mem_wdata_i;
            end else if (w_gnt || w_mis_done) begin
                r_req_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else begin
            case ({w_gnt, w_rsp})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_rdata <= '0;
            r_res_err   <= 1'b0;
        end else begin
            r_res_valid <= w_rsp | w_mis_done;
            if (w_rsp) begin
                r_res_id    <= ID_WIDTH'(w_head.id);
                r_res_err   <= data_err_i;
                r_res_rdata <= w_head.we ? '0 : w_load_data;
            end else if (w_mis_done) begin
                r_res_id    <= r_id;
                r_res_err   <= 1'b1;
                r_res_rdata <= '0;
            end
        end
    end

    assign x_mem_result_valid_o = r_res_valid;
    assign x_mem_result_id_o    = r_res_id;
    assign x_mem_result_rdata_o = r_res_rdata;
    assign x_mem_result_err_o   = r_res_err;

    a_rvalid_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni) data_rvalid_i |-> (r_count != '0)
    ) else $warning("xif_mem_responder: data_rvalid_i ignored, no transaction outstanding");

endmodule

// File: tb/tb_xif_mem_responder.sv
// Directed scoreboard bench for xif_mem_responder with a scripted OBI slave.
module tb_xif_mem_responder;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] rdata;
        logic        err;
        logic        mis;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          gdly;
        int          lat;
    } bus_t;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        x_mem_valid_i;
    logic        x_mem_ready_o;
    logic [3:0]  x_mem_id_i;
    logic [31:0] x_mem_addr_i;
    logic        x_mem_we_i;
    logic [1:0]  x_mem_size_i;
    logic [31:0] x_mem_wdata_i;
    logic        x_mem_last_i;
    logic        x_mem_result_valid_o;
    logic [3:0]  x_mem_result_id_o;
    logic [31:0] x_mem_result_rdata_o;
    logic        x_mem_result_err_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;

    exp_t exp_q[$];
    bus_t bus_q[$];
    rsp_t rsp_q[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   n_valid = 0;
    int   cyc     = 0;

    xif_mem_responder #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .ID_WIDTH       (4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .x_mem_valid_i       (x_mem_valid_i),
        .x_mem_ready_o       (x_mem_ready_o),
        .x_mem_id_i          (x_mem_id_i),
        .x_mem_addr_i        (x_mem_addr_i),
        .x_mem_we_i          (x_mem_we_i),
        .x_mem_size_i        (x_mem_size_i),
        .x_mem_wdata_i       (x_mem_wdata_i),
        .x_mem_last_i        (x_mem_last_i),
        .x_mem_result_valid_o(x_mem_result_valid_o),
        .x_mem_result_id_o   (x_mem_result_id_o),
        .x_mem_result_rdata_o(x_mem_result_rdata_o),
        .x_mem_result_err_o  (x_mem_result_err_o),
        .data_req_o          (data_req_o),
        .data_gnt_i          (data_gnt_i),
        .data_addr_o         (data_addr_o),
        .data_we_o           (data_we_o),
        .data_be_o           (data_be_o),
        .data_wdata_o        (data_wdata_o),
        .data_rvalid_i       (data_rvalid_i),
        .data_rdata_i        (data_rdata_i),
        .data_err_i          (data_err_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] id, input logic [31:0] rdata, input logic err,
                            input logic mis);
        exp_q.push_back('{id: id, rdata: rdata, err: err, mis: mis});
    endtask

    task automatic push_bus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input logic err, input int gdly, input int lat);
        bus_q.push_back('{addr: addr, we: we, be: be, wdata: wdata, rdata: rdata, err: err,
                          gdly: gdly, lat: lat});
    endtask

    task automatic issue(input logic [3:0] id, input logic [31:0] addr, input logic we,
                         input logic [1:0] size, input logic [31:0] wdata, output int waits);
        bit accepted;
        accepted = 1'b0;
        waits    = 0;
        @(negedge clk_i);
        x_mem_valid_i = 1'b1;
        x_mem_id_i    = id;
        x_mem_addr_i  = addr;
        x_mem_we_i    = we;
        x_mem_size_i  = size;
        x_mem_wdata_i = wdata;
        x_mem_last_i  = 1'b1;
        for (int i = 0; i < 100 && !accepted; i++) begin
            #1;
            if (x_mem_ready_o) accepted = 1'b1;
            else begin
                waits++;
                @(negedge clk_i);
            end
        end
        if (!accepted) begin
            n_cmp++;
            n_bad++;
            $display("FAIL handshake_timeout: id=%0d never accepted, expected ready", id);
        end
        @(posedge clk_i);
        #1;
        x_mem_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (exp_q.size() != 0 || bus_q.size() != 0); i++) begin
            @(negedge clk_i);
        end
        check("drain_pending_results", exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, x_mem_ready_o, 0);
        check({tag, "_res_valid"}, x_mem_result_valid_o, 0);
        check({tag, "_res_id"}, x_mem_result_id_o, 0);
        check({tag, "_res_rdata"}, x_mem_result_rdata_o, 0);
        check({tag, "_res_err"}, x_mem_result_err_o, 0);
        check({tag, "_req"}, data_req_o, 0);
        check({tag, "_addr"}, data_addr_o, 0);
        check({tag, "_we"}, data_we_o, 0);
        check({tag, "_be"}, data_be_o, 0);
        check({tag, "_wdata"}, data_wdata_o, 0);
    endtask

    // OBI slave: checks the presented request, grants after gdly cycles, answers lat later.
    initial begin
        int wait_cnt;
        rsp_t r;
        wait_cnt      = 0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;
        data_err_i    = 1'b0;
        forever begin
            @(negedge clk_i);
            #2;
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
            data_rdata_i  = '0;
            data_err_i    = 1'b0;
            if (rsp_q.size() != 0 && rsp_q[0].due <= cyc + 1) begin
                r = rsp_q.pop_front();
                data_rvalid_i = 1'b1;
                data_rdata_i  = r.rdata;
                data_err_i    = r.err;
            end
            if (rst_ni && data_req_o) begin
                if (bus_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_bus_req: addr=0x%08h, expected no data_req_o",
                             data_addr_o);
                end else begin
                    check("bus_addr", data_addr_o, bus_q[0].addr);
                    check("bus_we", data_we_o, bus_q[0].we);
                    check("bus_be", data_be_o, bus_q[0].be);
                    if (bus_q[0].we) check("bus_wdata", data_wdata_o, bus_q[0].wdata);
                    if (wait_cnt >= bus_q[0].gdly) begin
                        data_gnt_i = 1'b1;
                        rsp_q.push_back('{due: cyc + 1 + bus_q[0].lat, rdata: bus_q[0].rdata,
                                          err: bus_q[0].err});
                        void'(bus_q.pop_front());
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    // Result monitor: pops the scoreboard whenever a result strobe is seen.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_ni && x_mem_result_valid_o) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: id=%0d rdata=0x%08h err=%0b, expected none",
                             x_mem_result_id_o, x_mem_result_rdata_o, x_mem_result_err_o);
                end else begin
                    e = exp_q.pop_front();
                    check("result_id", x_mem_result_id_o, e.id);
                    check("result_rdata", x_mem_result_rdata_o, e.rdata);
                    check("result_err", x_mem_result_err_o, e.err);
                    if (!e.mis) check("result_after_rvalid", data_rvalid_i, 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int waits;
        int nv;
        rst_ni        = 1'b0;
        x_mem_valid_i = 1'b0;
        x_mem_id_i    = '0;
        x_mem_addr_i  = '0;
        x_mem_we_i    = 1'b0;
        x_mem_size_i  = '0;
        x_mem_wdata_i = '0;
        x_mem_last_i  = 1'b1;
        repeat (3) @(negedge clk_i);
        check_idle_outputs("reset");
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // Word load, gnt immediately, rvalid two cycles later.
        push_bus(32'h100, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, 0, 2);
        push_exp(4'd3, 32'hDEADBEEF, 1'b0, 1'b0);
        issue(4'd3, 32'h100, 1'b0, 2'd2, 32'h0, waits);
        drain();

        // Byte store to lane 3; slave read data must not leak into the result.
        push_bus(32'h100, 1'b1, 4'b1000, 32'hAB000000, 32'hFFFFFFFF, 1'b0, 0, 1);
        push_exp(4'd4, 32'h0, 1'b0, 1'b0);
        issue(4'd4, 32'h103, 1'b1, 2'd0, 32'h000000AB, waits);
        drain();

        // Half load upper half, byte load lane 1, half store upper half.
        push_bus(32'h100, 1'b0, 4'b1100, 32'h0, 32'h1234ABCD, 1'b0, 1, 1);
        push_exp(4'd5, 32'h00001234, 1'b0, 1'b0);
        issue(4'd5, 32'h102, 1'b0, 2'd1, 32'h0, waits);
        push_bus(32'h100, 1'b0, 4'b0010, 32'h0, 32'h1234ABCD, 1'b0, 0, 3);
        push_exp(4'd6, 32'h000000AB, 1'b0, 1'b0);
        issue(4'd6, 32'h101, 1'b0, 2'd0, 32'h0, waits);
        push_bus(32'h104, 1'b1, 4'b1100, 32'h55660000, 32'h0, 1'b0, 0, 1);
        push_exp(4'd7, 32'h0, 1'b0, 1'b0);
        issue(4'd7, 32'h106, 1'b1, 2'd1, 32'h00005566, waits);
        drain();

        // Delayed grant, two outstanding, then grant and rvalid in the same cycle.
        push_bus(32'h200, 1'b0, 4'hF, 32'h0, 32'h11111111, 1'b0, 3, 3);
        push_exp(4'd1, 32'h11111111, 1'b0, 1'b0);
        issue(4'd1, 32'h200, 1'b0, 2'd2, 32'h0, waits);
        push_bus(32'h204, 1'b0, 4'hF, 32'h0, 32'h22222222, 1'b0, 0, 3);
        push_exp(4'd2, 32'h22222222, 1'b0, 1'b0);
        issue(4'd2, 32'h204, 1'b0, 2'd2, 32'h0, waits);
        check("held_req_wait_cycles", waits, 4);
        push_bus(32'h208, 1'b0, 4'hF, 32'h0, 32'h33333333, 1'b0, 0, 2);
        push_exp(4'd9, 32'h33333333, 1'b0, 1'b0);
        issue(4'd9, 32'h208, 1'b0, 2'd2, 32'h0, waits);
        check("two_outstanding_wait_cycles", waits, 2);
        drain();

        // Misaligned word load with nothing outstanding: no bus access, err result.
        push_exp(4'd7, 32'h0, 1'b1, 1'b1);
        issue(4'd7, 32'h101, 1'b0, 2'd2, 32'h0, waits);
        check("misaligned_idle_wait_cycles", waits, 0);
        drain();

        // Misaligned half held off until an outstanding load has fully returned.
        push_bus(32'h300, 1'b0, 4'hF, 32'h0, 32'h0BADF00D, 1'b0, 0, 6);
        push_exp(4'd8, 32'h0BADF00D, 1'b0, 1'b0);
        issue(4'd8, 32'h300, 1'b0, 2'd2, 32'h0, waits);
        push_exp(4'd10, 32'h0, 1'b1, 1'b1);
        issue(4'd10, 32'h301, 1'b0, 2'd1, 32'h0, waits);
        check("misaligned_busy_wait_cycles", waits, 8);
        push_exp(4'd11, 32'h0, 1'b1, 1'b1);
        issue(4'd11, 32'h400, 1'b0, 2'd3, 32'h0, waits);
        drain();

        // Bus error on a word load.
        push_bus(32'h500, 1'b0, 4'hF, 32'h0, 32'h12345678, 1'b1, 0, 1);
        push_exp(4'd12, 32'h12345678, 1'b1, 1'b0);
        issue(4'd12, 32'h500, 1'b0, 2'd2, 32'h0, waits);
        drain();

        // Reset with two outstanding; the late responses must be ignored.
        push_bus(32'h600, 1'b0, 4'hF, 32'h0, 32'h600D0001, 1'b0, 0, 20);
        push_bus(32'h604, 1'b0, 4'hF, 32'h0, 32'h600D0002, 1'b0, 0, 20);
        issue(4'd13, 32'h600, 1'b0, 2'd2, 32'h0, waits);
        issue(4'd14, 32'h604, 1'b0, 2'd2, 32'h0, waits);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_idle_outputs("midreset");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        nv = n_valid;
        repeat (30) @(negedge clk_i);
        check("results_after_reset", n_valid - nv, 0);
        check("late_responses_delivered", rsp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xif_mem_responder.md
Name: xif_mem_responder

Overview:
- Core-side responder for the CV-X-IF memory request/result channel issued by the FPU subsystem (FP loads/stores).
- Accepts x_mem requests, registers them, and drives them onto the core's OBI data port.
- Tracks outstanding bus transactions in order and returns one x_mem result per accepted request (loads and stores), with aligned read data and error flag.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; fixed at 32 in this revision
ID_WIDTH, 4, X-IF instruction id width
MAX_OUTSTANDING, 2, maximum granted-but-unanswered OBI transactions (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
x_mem_valid_i  in  1  request valid from coprocessor
x_mem_ready_o  out  1  request accepted this cycle when high with valid
x_mem_id_i  in  ID_WIDTH  instruction id of request
x_mem_addr_i  in  ADDR_WIDTH  byte address
x_mem_we_i  in  1  1=store, 0=load
x_mem_size_i  in  2  0=byte, 1=half, 2=word (3 illegal, treated as misaligned)
x_mem_wdata_i  in  DATA_WIDTH  store data, LSB-justified
x_mem_last_i  in  1  must be 1 (single-access requests only); not otherwise used
x_mem_result_valid_o  out  1  one-cycle result strobe; no ready (X-IF)
x_mem_result_id_o  out  ID_WIDTH  id of completing request
x_mem_result_rdata_o  out  DATA_WIDTH  load data, right-aligned, zero-extended; 0 for stores
x_mem_result_err_o  out  1  bus error or misaligned access
data_req_o  out  1  OBI request
data_gnt_i  in  1  OBI grant
data_addr_o  out  ADDR_WIDTH  word-aligned address (addr[1:0]=0)
data_we_o  out  1  OBI write enable
data_be_o  out  4  byte enables
data_wdata_o  out  DATA_WIDTH  store data shifted to byte lane
data_rvalid_i  in  1  OBI response valid
data_rdata_i  in  DATA_WIDTH  OBI read data
data_err_i  in  1  OBI error

Behaviour:
- Reset: all outputs 0; request register empty; outstanding count 0; metadata FIFO empty; result register invalid.
- Request register: x_mem_ready_o = ~req_full_q & (count < MAX_OUTSTANDING) & (misaligned ? count==0 & ~res_pending : 1). On handshake, id/addr/we/size/wdata latched, req_full_q=1.
- Bus phase: data_req_o = req_full_q & aligned; address/we/be/wdata held stable until data_gnt_i (OBI rule). Minimum latency handshake->data_req_o: 1 cycle.
- be = (size0: 4'b0001, size1: 4'b0011, size2: 4'b1111) << addr[1:0]; wdata << 8*addr[1:0].
- Misaligned: size1 & addr[0], size2 & addr[1:0]!=0, size3. Never driven to bus; accepted only with count==0, so in-order holds. Cycle after acceptance: req_full_q cleared, result emitted next cycle with err=1, rdata=0.
- On gnt: push {id, we, addr[1:0], size} to FIFO; count+1; req_full_q cleared same edge; a new x_mem handshake is allowed in the gnt cycle only if count+1 < MAX_OUTSTANDING (ready computed from registered count, conservative: ready low while req_full_q).
- On data_rvalid_i: pop FIFO head; result registered: x_mem_result_valid_o=1 exactly one cycle after rvalid, id=head id, err=data_err_i, rdata = (data_rdata_i >> 8*offset) masked to size for loads, 0 for stores; count-1.
- gnt and rvalid in same cycle: push and pop both; count unchanged.
- rvalid with count==0: ignored (no result); simulation assertion fires.
- Results strictly in request order; one result per accepted request.
- Reset mid-operation: all state cleared immediately; late OBI responses after reset fall under the count==0 rule.

Decomposition:
- Package xif_mem_pkg: mem_size_e (BYTE/HALF/WORD), mem_meta_t {id, we, offset[1:0], size}, helper function for be generation.
- Sub-module xif_mem_meta_fifo: synchronous FIFO of mem_meta_t, depth MAX_OUTSTANDING, push/pop/full/empty, simultaneous push+pop supported when non-empty.

Test Plan:
- Word load id=3 addr=0x100, gnt same cycle, rvalid 2 cycles later rdata=0xDEADBEEF -> data_be_o=4'hF, result_valid one cycle after rvalid, id=3, rdata=0xDEADBEEF, err=0.
- Byte store addr=0x103 wdata=0xAB -> data_addr_o=0x100, be=4'b1000, wdata=0xAB000000; result_valid with rdata=0, err=0.
- Half load addr=0x102, rdata=0x1234ABCD -> result rdata=0x00001234.
- Back-to-back loads id=1,id=2, gnt delayed 3 cycles, MAX_OUTSTANDING=2 -> req held stable until gnt; ready low while two outstanding; results in order id=1 then id=2; gnt+rvalid same cycle keeps count.
- Word load addr=0x101 with count 0 -> no data_req_o; result err=1 id correct; with count=1 ready stays low until drained.
- data_err_i=1 on rvalid -> result err=1; rst_ni asserted with 2 outstanding -> all outputs 0, subsequent rvalid produces no result.
